// File: rtl/exmem_if.sv
// exmem_if: execute-side inputs and memory-stage outputs of the EX/MEM pipeline register
interface exmem_if;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic [4:0]  ex_rd_i;
    logic        ex_we_rf_i;
    logic [31:0] ex_result_i;
    logic        ex_is_mem_i;
    logic        ex_we_mem_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_mem_data_i;
    logic [31:0] ex_mem_addr_i;
    logic        stall_i;
    logic        flush_i;
    logic        mem_ack_i;
    logic        mem_err_i;
    logic        mem_misaligned_i;
    logic        ex_stall_o;
    logic        mem_valid_o;
    logic [31:0] mem_pc_o;
    logic [4:0]  mem_rd_o;
    logic        mem_we_rf_o;
    logic [31:0] mem_result_o;
    logic        mem_is_mem_o;
    logic        mem_we_mem_o;
    logic [2:0]  mem_funct3_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_addr_o;
    logic        mem_done_o;
    logic        e_bus_err_o;
    logic        e_bus_timeout_o;
    modport slave (
        input  ex_valid_i, ex_pc_i, ex_rd_i, ex_we_rf_i, ex_result_i, ex_is_mem_i, ex_we_mem_i,
               ex_funct3_i, ex_mem_data_i, ex_mem_addr_i, stall_i, flush_i, mem_ack_i, mem_err_i,
               mem_misaligned_i,
        output ex_stall_o, mem_valid_o, mem_pc_o, mem_rd_o, mem_we_rf_o, mem_result_o, mem_is_mem_o,
               mem_we_mem_o, mem_funct3_o, mem_data_o, mem_addr_o, mem_done_o, e_bus_err_o,
               e_bus_timeout_o
    );
    modport master (
        output ex_valid_i, ex_pc_i, ex_rd_i, ex_we_rf_i, ex_result_i, ex_is_mem_i, ex_we_mem_i,
               ex_funct3_i, ex_mem_data_i, ex_mem_addr_i, stall_i, flush_i, mem_ack_i, mem_err_i,
               mem_misaligned_i,
        input  ex_stall_o, mem_valid_o, mem_pc_o, mem_rd_o, mem_we_rf_o, mem_result_o, mem_is_mem_o,
               mem_we_mem_o, mem_funct3_o, mem_data_o, mem_addr_o, mem_done_o, e_bus_err_o,
               e_bus_timeout_o
    );
endinterface

// File: rtl/exmem_reg.sv
// exmem_reg: EX/MEM pipeline register that holds memory ops on the bus until they complete
module exmem_reg #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic clk_i,
    input logic rst_i,
    exmem_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_GAP} state_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we_rf;
        logic [31:0] result;
        logic        is_mem;
        logic        we_mem;
        logic [2:0]  funct3;
        logic [31:0] data;
        logic [31:0] addr;
    } payload_t;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    state_t     state_q, state_d;
    payload_t   pl_q, pl_d, ex_pl;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d, err_q, err_d, tmo_q, tmo_d;
    logic       timeout, complete, advance, mem_op;
    // Completion detection, next state, payload capture, wait counter and result pulses
    always_comb begin
        ex_pl = {bus.ex_valid_i, bus.ex_pc_i, bus.ex_rd_i, bus.ex_we_rf_i, bus.ex_result_i,
                 bus.ex_is_mem_i, bus.ex_we_mem_i, bus.ex_funct3_i, bus.ex_mem_data_i, bus.ex_mem_addr_i};
        timeout = cnt_q == CNT_LAST;
        complete = state_q == S_WAIT && (bus.mem_ack_i || bus.mem_err_i || bus.mem_misaligned_i || timeout);
        advance = !bus.stall_i && (state_q == S_IDLE || state_q == S_HOLD || complete);
        mem_op = bus.ex_valid_i && bus.ex_is_mem_i;
        state_d = state_q;
        pl_d = pl_q;
        cnt_d = cnt_q;
        if (bus.flush_i) begin
            pl_d.valid = 1'b0;
            pl_d.is_mem = 1'b0;
            state_d = S_IDLE;
            cnt_d = '0;
        end else if (advance) begin
            pl_d = ex_pl;
            state_d = !mem_op ? S_IDLE : complete ? S_GAP : S_WAIT;
            cnt_d = '0;
        end else if (complete) begin
            state_d = S_HOLD;
        end else if (state_q == S_GAP) begin
            state_d = S_WAIT;
            cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 8'd1;
        end
        done_d = complete && !bus.flush_i;
        err_d = done_d && bus.mem_err_i && !bus.mem_ack_i;
        tmo_d = done_d && timeout && !bus.mem_ack_i && !bus.mem_err_i && !bus.mem_misaligned_i;
    end
    // State, payload, counter and pulse registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pl_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pl_q <= pl_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
            err_q <= err_d;
            tmo_q <= tmo_d;
        end
    end
    assign bus.ex_stall_o = bus.stall_i || (state_q == S_WAIT && !complete) || state_q == S_GAP;
    assign bus.mem_valid_o = pl_q.valid;
    assign bus.mem_pc_o = pl_q.pc;
    assign bus.mem_rd_o = pl_q.rd;
    assign bus.mem_we_rf_o = pl_q.we_rf;
    assign bus.mem_result_o = pl_q.result;
    assign bus.mem_is_mem_o = pl_q.is_mem && state_q == S_WAIT;
    assign bus.mem_we_mem_o = pl_q.we_mem;
    assign bus.mem_funct3_o = pl_q.funct3;
    assign bus.mem_data_o = pl_q.data;
    assign bus.mem_addr_o = pl_q.addr;
    assign bus.mem_done_o = done_q;
    assign bus.e_bus_err_o = err_q;
    assign bus.e_bus_timeout_o = tmo_q;
endmodule

// File: doc/exmem_reg.md
# exmem_reg

Execute-to-memory pipeline register that sits directly upstream of the memory stage and drives its request inputs (is_mem, we_mem, funct3, store data, address). It holds each memory instruction stable until the bus completes it with ack, error, misalignment or timeout. While the instruction is held, it stalls execute. It inserts a one-cycle strobe gap between back-to-back memory operations and supports flush and downstream stall.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles a memory op may wait in WAIT before forced completion (1..255)
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- ex_valid_i  in  1  execute presents a valid instruction
- ex_pc_i  in  32  instruction PC
- ex_rd_i  in  5  destination register
- ex_we_rf_i  in  1  register-file write enable
- ex_result_i  in  32  ALU result
- ex_is_mem_i  in  1  load/store
- ex_we_mem_i  in  1  store (1) / load (0)
- ex_funct3_i  in  3  access size/sign
- ex_mem_data_i  in  32  store data
- ex_mem_addr_i  in  32  effective address
- stall_i  in  1  downstream/hazard stall
- flush_i  in  1  kill register contents
- mem_ack_i, mem_err_i  in  1  bus ack / bus error (same cycle as bus)
- mem_misaligned_i  in  1  OR of memory-stage load/store misalignment flags
- ex_stall_o  out  1  execute must hold its outputs
- mem_valid_o, mem_pc_o[32], mem_rd_o[5], mem_we_rf_o, mem_result_o[32]  out  registered payload
- mem_is_mem_o, mem_we_mem_o, mem_funct3_o[3], mem_data_o[32], mem_addr_o[32]  out  memory-stage request
- mem_done_o  out  1  registered one-cycle pulse: held memory op completed
- e_bus_err_o, e_bus_timeout_o  out  1  registered one-cycle pulses qualifying mem_done_o

## Operation
- States: IDLE (empty or non-memory op), WAIT (memory op on bus), HOLD (completed, downstream stalled), GAP (next memory op loaded, strobe suppressed).
- complete = WAIT && (mem_ack_i || mem_err_i || mem_misaligned_i || cnt == TIMEOUT_CYCLES-1).
- advance = !stall_i && (IDLE || HOLD || complete).
- ex_stall_o = stall_i || WAIT && !complete || GAP.
- On advance, all payload registers load from ex_*, and mem_valid_o = ex_valid_i.
- Next state on advance:
  - valid memory op from IDLE/HOLD: WAIT.
  - valid memory op from complete: GAP.
  - otherwise: IDLE.
- complete && stall_i: HOLD; payload kept, mem_valid_o stays 1.
- GAP lasts exactly one cycle, then WAIT; payload unchanged.
- mem_is_mem_o = registered is_mem && state==WAIT. It is 0 in IDLE/HOLD/GAP, so the bus never re-requests a completed op.
- cnt width is 8 bits. It clears on WAIT entry and increments each WAIT cycle without completion.
- On complete: mem_done_o = 1 next cycle.
  - e_bus_err_o = mem_err_i.
  - e_bus_timeout_o = timeout && !mem_ack_i && !mem_err_i.
  - Priority is ack > err > misaligned > timeout; only the highest-priority cause is flagged.
- flush_i has priority over advance.
  - Clears mem_valid_o, mem_is_mem_o and cnt; state becomes IDLE.
  - Abandons any WAIT op and raises no done or error pulse.
- An invalid instruction loads as a bubble: mem_valid_o = 0, state IDLE regardless of ex_is_mem_i.

## Timing
- Reset: every output 0, state IDLE, cnt 0; ex_stall_o = stall_i.
- Non-memory op: latency 1 cycle, throughput 1/cycle.
- Memory op: mem_is_mem_o rises the cycle after load. The op retires on the edge where mem_ack_i is sampled high, so a 1-cycle ack gives 1 WAIT cycle.
- Back-to-back memory ops: completion edge → GAP (1 cycle) → WAIT. Minimum spacing is WAIT + 1 cycle.
- Timeout: with no response, complete fires in the TIMEOUT_CYCLES-th WAIT cycle.
- mem_done_o and the error pulses assert the cycle after complete, for exactly 1 cycle.
- Reset mid-WAIT behaves as flush and also clears all pulses.

## Test plan
- Reset then ALU op (ex_valid_i=1, ex_result_i=0x1234, rd=5) → next cycle mem_valid_o=1, mem_result_o=0x1234, mem_is_mem_o=0, ex_stall_o=0.
- Load at 0x100, ack after 3 cycles → mem_is_mem_o high 3 cycles; ex_stall_o high until the ack cycle; mem_done_o one pulse; no error flags.
- Two stores back-to-back, each with a 1-cycle ack → mem_is_mem_o pattern 1,0,1; the second payload appears on the first completion edge.
- Load with no ack, TIMEOUT_CYCLES=4 → complete on the 4th WAIT cycle; e_bus_timeout_o=1 for 1 cycle; mem_is_mem_o drops.
- Ack while stall_i=1 for 2 cycles → HOLD.
  - mem_is_mem_o=0 and payload stable for 2 cycles.
  - Next instruction loads on the first edge with stall_i=0.
- flush_i during WAIT with a simultaneous mem_err_i → mem_valid_o=0, state IDLE, e_bus_err_o stays 0.
